dsr_seq_driver: RTL



---
 rtl/dsr_pkg.sv | 46 ++++
 rtl/dsr_expect.sv | 29 ++
 rtl/dsr_seq_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dsr_pkg.sv
// Shared definitions for the DSR processing FSM and its initiator-side sequencer:
// state/step encodings, mode selection and the script byte constants.
package dsr_pkg;

  // Encoding of the receiver's own 9-state processing FSM.
  typedef enum logic [3:0] {
    DSR_IDLE  = 4'd0,
    DSR_HDR   = 4'd1,
    DSR_READ  = 4'd2,
    DSR_WAIT  = 4'd3,
    DSR_PROC1 = 4'd4,
    DSR_PROC2 = 4'd5,
    DSR_PROC3 = 4'd6,
    DSR_DONE  = 4'd7,
    DSR_ERR   = 4'd8
  } dsr_state_e;

  // Driver steps; the encoding doubles as the reported fail_step code.
  typedef enum logic [3:0] {
    D_START = 4'd0,
    D_HDR   = 4'd1,
    D_READ  = 4'd2,
    D_WAIT  = 4'd3,
    D_PROC1 = 4'd4,
    D_PROC2 = 4'd5,
    D_PROC3 = 4'd6,
    D_DONE  = 4'd7,
    D_ERR   = 4'd8,
    D_IDLE  = 4'd9
  } drv_step_e;

  typedef enum logic [1:0] {
    M_FULL  = 2'd0,
    M_WAIT  = 2'd1,
    M_ERROR = 2'd2,
    M_RSVD  = 2'd3
  } mode_e;

  localparam logic [7:0] HDR_OK       = 8'h01;
  localparam logic [7:0] READ_GO      = 8'h0A;
  localparam logic [7:0] WAIT_EXIT    = 8'h10;
  localparam logic [7:0] ERR_EXIT     = 8'h07;
  localparam logic [7:0] ERR_CODE     = 8'hEE;
  localparam logic [3:0] STEP_BADMODE = 4'hF;

endpackage

// File: rtl/dsr_expect.sv
// Combinational prediction of the DSR's data_out/done for a given driver step
// and the byte the driver is presenting in that step.
module dsr_expect
  import dsr_pkg::*;
(
  input  drv_step_e   i_step,
  input  logic [7:0]  i_drv,
  output logic [7:0]  o_data,
  output logic        o_done
);

  always_comb begin
    o_data = '0;
    o_done = 1'b0;
    case (i_step)
      D_READ:  o_data = i_drv;
      D_PROC1: o_data = i_drv + 8'd1;
      D_PROC2: o_data = {i_drv[6:0], 1'b0};
      D_PROC3: o_data = ~i_drv;
      D_DONE: begin
        o_data = i_drv;
        o_done = 1'b1;
      end
      D_ERR:   o_data = ERR_CODE;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dsr_seq_driver.sv
// Built-in self-test master for the DSR: plays a byte script per mode and checks
// the DSR's responses each cycle. Optional auto-relaunch loop: DSR_SEQ_LOOP_EN.
module dsr_seq_driver
  import dsr_pkg::*;
#(
  parameter int unsigned WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [7:0]        payload,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              dsr_start,
  output logic [7:0]        dsr_data_in,
  input  logic [7:0]        dsr_data_out,
  input  logic              dsr_done,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [3:0]        fail_step,
  output logic [7:0]        fail_obs
`ifdef DSR_SEQ_LOOP_EN
  ,
  output logic [15:0]       pass_cnt
`endif
);

  drv_step_e         r_state, w_nxt;
  mode_e             r_mode, w_mode_sel;
  logic [7:0]        r_p;
  logic [WAIT_W-1:0] r_n, r_cnt;
  logic              r_detour;
  logic              r_pass, r_fail;
  logic [3:0]        r_fail_step;
  logic [7:0]        r_fail_obs;

  logic       w_launch, w_relaunch, w_exit, w_last, w_bad, w_start;
  logic [7:0] w_drv, w_exp_data;
  logic       w_exp_done;

`ifdef DSR_SEQ_LOOP_EN
  logic        r_loop;
  logic [15:0] r_pass_cnt;
  assign w_relaunch = r_loop;
  assign pass_cnt   = r_pass_cnt;
`else
  assign w_relaunch = 1'b0;
`endif

  dsr_expect u_expect (
    .i_step (r_state),
    .i_drv  (w_drv),
    .o_data (w_exp_data),
    .o_done (w_exp_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= D_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_drv      = '0;
    w_start    = 1'b0;
    w_last     = 1'b0;
    w_exit     = (r_cnt == r_n);
    w_mode_sel = w_relaunch ? r_mode : mode_e'(mode);
    w_launch   = 1'b0;
    case (r_state)
      D_IDLE: begin
        w_launch = go || w_relaunch;
        if (w_launch && (w_mode_sel != M_RSVD)) w_nxt = D_START;
      end
      D_START: begin
        w_start = 1'b1;
        w_nxt   = D_HDR;
      end
      D_HDR: begin
        w_drv = (r_mode == M_ERROR) ? 8'h00 : HDR_OK;
        w_nxt = (r_mode == M_ERROR) ? D_ERR : D_READ;
      end
      D_READ: begin
        // WAIT mode takes one detour through D_WAIT before reading for real
        if ((r_mode == M_FULL) || r_detour) begin
          w_drv = READ_GO;
          w_nxt = D_PROC1;
        end else begin
          w_nxt = D_WAIT;
        end
      end
      D_WAIT: begin
        w_drv = w_exit ? WAIT_EXIT : 8'h00;
        w_nxt = w_exit ? D_READ : D_WAIT;
      end
      D_PROC1: begin
        w_drv = r_p;
        w_nxt = D_PROC2;
      end
      D_PROC2: begin
        w_drv = r_p | 8'h80;
        w_nxt = D_PROC3;
      end
      D_PROC3: begin
        w_drv = r_p;
        w_nxt = D_DONE;
      end
      D_DONE: begin
        w_drv  = r_p;
        w_last = 1'b1;
        w_nxt  = D_IDLE;
      end
      D_ERR: begin
        w_drv  = w_exit ? ERR_EXIT : 8'h00;
        w_last = w_exit;
        w_nxt  = w_exit ? D_IDLE : D_ERR;
      end
      default: w_nxt = D_IDLE;
    endcase
    w_bad = (r_state != D_IDLE) &&
            ((dsr_data_out != w_exp_data) || (dsr_done != w_exp_done));
    if (w_bad) w_nxt = D_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= M_FULL;
      r_p         <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_detour    <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_step <= '0;
      r_fail_obs  <= '0;
`ifdef DSR_SEQ_LOOP_EN
      r_loop      <= 1'b0;
      r_pass_cnt  <= '0;
`endif
    end else begin
      if ((r_state == D_WAIT) || (r_state == D_ERR)) r_cnt <= r_cnt + 1'b1;
      else                                           r_cnt <= '0;
      if ((r_state == D_WAIT) && w_exit) r_detour <= 1'b1;

      if (w_launch) begin
        r_detour    <= 1'b0;
        r_pass      <= 1'b0;
        r_fail      <= 1'b0;
        r_fail_step <= '0;
        r_fail_obs  <= '0;
        if (w_relaunch) begin
          r_p <= r_p + 8'd1;
        end else begin
          r_mode <= mode_e'(mode);
          r_p    <= payload;
          r_n    <= wait_cycles;
        end
        if (w_mode_sel == M_RSVD) begin
          r_fail      <= 1'b1;
          r_fail_step <= STEP_BADMODE;
        end
`ifdef DSR_SEQ_LOOP_EN
        r_loop <= 1'b0;
`endif
      end

      if (w_bad) begin
        r_fail      <= 1'b1;
        r_fail_step <= r_state;
        r_fail_obs  <= dsr_data_out;
      end else if (w_last) begin
        r_pass <= 1'b1;
`ifdef DSR_SEQ_LOOP_EN
        r_loop <= go;
        if (r_pass_cnt != 16'hFFFF) r_pass_cnt <= r_pass_cnt + 16'd1;
`endif
      end
    end
  end

  assign dsr_start   = w_start;
  assign dsr_data_in = w_drv;
  assign busy        = (r_state != D_IDLE);
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_step   = r_fail_step;
  assign fail_obs    = r_fail_obs;

endmodule
